dht_sched: RTL and testbench

- Measurement scheduler and validator for the DHT11 single-wire reader.
- Decides when a sensor transaction starts: periodic auto-trigger or on-demand request, while enforcing the sensor's minimum inter-read gap.
- Supervises each transaction with a timeout, verifies the 40-bit frame checksum, retries failed reads and publishes the last good temperature/humidity to the roof control logic.
- Sits between the reader (start/done/40-bit frame interface) and the consumers.

---
 rtl/dht_sched.sv | 168 ++++++++++++++++
 tb/tb_dht_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht_sched.sv
// ============================================================================
// Module : dht_sched
// Brief  : DHT11 measurement scheduler: trigger gating, timeout, checksum
//          validation, retries and last-good humidity/temperature capture.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dht_sched #(
    parameter int MIN_GAP_CYC = 100_000_000,
    parameter int PERIOD_CYC  = 250_000_000,
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_auto_en,
    input  logic        i_req,
    output logic        o_start,
    input  logic        i_done,
    input  logic [39:0] i_data,
    output logic [7:0]  o_humi,
    output logic [7:0]  o_temp,
    output logic        o_valid,
    output logic        o_upd,
    output logic        o_err,
    output logic [7:0]  o_fail_cnt,
    output logic [2:0]  o_state
);

    localparam int GAP_W = $clog2(MIN_GAP_CYC + 1);
    localparam int PER_W = $clog2(PERIOD_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [GAP_W-1:0] c_GAP_MAX   = GAP_W'(MIN_GAP_CYC);
    localparam logic [PER_W-1:0] c_PER_LAST  = PER_W'(PERIOD_CYC - 1);
    localparam logic [TO_W-1:0]  c_TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       c_MAX_RETRY = 4'(MAX_RETRY);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_CHECK = 3'd3;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [PER_W-1:0] r_per_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [3:0]       r_retry;
    logic             r_pend;
    logic [39:0]      r_frame;

    logic       w_per_wrap;
    logic       w_to_hit;
    logic [7:0] w_sum;
    logic       w_success;
    logic       w_fail;
    logic [3:0] w_retry_inc;
    logic       w_final;

    assign w_per_wrap  = i_auto_en && (r_per_cnt == c_PER_LAST);
    assign w_to_hit    = (r_state == c_WAIT) && !i_done && (r_to_cnt == c_TO_LAST);
    assign w_sum       = r_frame[39:32] + r_frame[31:24] + r_frame[23:16] + r_frame[15:8];
    assign w_success   = (r_state == c_CHECK) && (w_sum == r_frame[7:0]);
    assign w_fail      = ((r_state == c_CHECK) && (w_sum != r_frame[7:0])) || w_to_hit;
    assign w_retry_inc = r_retry + 4'd1;
    assign w_final     = w_fail && (w_retry_inc == c_MAX_RETRY);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (r_pend && (r_gap_cnt == c_GAP_MAX)) w_state_nxt = c_START;
            c_START: w_state_nxt = c_WAIT;
            c_WAIT: begin
                if (i_done) begin
                    w_state_nxt = c_CHECK;
                end else if (w_to_hit) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_CHECK: w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        o_start = (r_state == c_START);
        o_state = r_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap_cnt  <= '0;
            r_per_cnt  <= '0;
            r_to_cnt   <= '0;
            r_retry    <= '0;
            r_pend     <= 1'b0;
            r_frame    <= '0;
            o_humi     <= '0;
            o_temp     <= '0;
            o_valid    <= 1'b0;
            o_upd      <= 1'b0;
            o_err      <= 1'b0;
            o_fail_cnt <= '0;
        end else begin
            if (r_state == c_START) begin
                r_gap_cnt <= '0;
            end else if (r_gap_cnt != c_GAP_MAX) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end

            if (!i_auto_en || w_per_wrap) begin
                r_per_cnt <= '0;
            end else begin
                r_per_cnt <= r_per_cnt + PER_W'(1);
            end

            if (r_state == c_START) begin
                r_to_cnt <= '0;
            end else if ((r_state == c_WAIT) && !i_done && !w_to_hit) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if ((r_state == c_WAIT) && i_done) begin
                r_frame <= i_data;
            end

            // A new request in the same cycle as a clear keeps the next read queued
            if (i_req || w_per_wrap) begin
                r_pend <= 1'b1;
            end else if (w_success || w_final) begin
                r_pend <= 1'b0;
            end

            if (w_success || w_final) begin
                r_retry <= '0;
            end else if (w_fail) begin
                r_retry <= w_retry_inc;
            end

            if (w_fail && (o_fail_cnt != 8'hFF)) begin
                o_fail_cnt <= o_fail_cnt + 8'd1;
            end

            if (w_success) begin
                o_humi  <= r_frame[39:32];
                o_temp  <= r_frame[23:16];
                o_valid <= 1'b1;
            end

            o_upd <= w_success;
            o_err <= w_final;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dht_sched.sv
// ============================================================================
// Module : tb_dht_sched
// Brief  : Self-checking bench for dht_sched: vector table, directed corner
//          sequences and randomized traffic against a timestamp-based model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dht_sched;

    localparam int MIN_GAP = 20;
    localparam int PERIOD  = 100;
    localparam int TIMEOUT = 50;
    localparam int MAXR    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        auto_en = 1'b0;
    logic        req = 1'b0;
    logic        done = 1'b0;
    logic [39:0] data = '0;
    logic        o_start, o_valid, o_upd, o_err;
    logic [7:0]  o_humi, o_temp, o_fail_cnt;
    logic [2:0]  o_state;

    always #5 clk = ~clk;

    dht_sched #(
        .MIN_GAP_CYC (MIN_GAP),
        .PERIOD_CYC  (PERIOD),
        .TIMEOUT_CYC (TIMEOUT),
        .MAX_RETRY   (MAXR)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_auto_en  (auto_en),
        .i_req      (req),
        .o_start    (o_start),
        .i_done     (done),
        .i_data     (data),
        .o_humi     (o_humi),
        .o_temp     (o_temp),
        .o_valid    (o_valid),
        .o_upd      (o_upd),
        .o_err      (o_err),
        .o_fail_cnt (o_fail_cnt),
        .o_state    (o_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks transactions by timestamps rather than states
    int          cyc;
    bit          m_busy, m_seen, m_pend, m_valid, m_upd, m_err;
    int          m_start_cyc, m_last_start, m_per, m_tries, m_fails;
    logic [39:0] m_frame;
    logic [7:0]  m_humi, m_temp;

    task automatic m_reset();
        cyc = 0; m_busy = 0; m_seen = 0; m_pend = 0; m_valid = 0;
        m_upd = 0; m_err = 0; m_start_cyc = 0; m_last_start = -1;
        m_per = 0; m_tries = 0; m_fails = 0; m_frame = '0;
        m_humi = '0; m_temp = '0;
    endtask

    function automatic bit frame_ok(input logic [39:0] f);
        int s;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        return (s % 256) == int'(f[7:0]);
    endfunction

    function automatic logic [30:0] m_out();
        logic [2:0] st;
        bit         s;
        s  = m_busy && (cyc == m_start_cyc);
        st = !m_busy ? 3'd0 : s ? 3'd1 : m_seen ? 3'd3 : 3'd2;
        return {s, st, m_valid, m_upd, m_err, m_humi, m_temp, 8'(m_fails)};
    endfunction

    function automatic logic [30:0] dut_out();
        return {o_start, o_state, o_valid, o_upd, o_err, o_humi, o_temp, o_fail_cnt};
    endfunction

    task automatic m_step(input bit r, input bit a, input bit d, input logic [39:0] dt);
        bit set, clr, succ, fail;
        set = r || (a && m_per == PERIOD - 1);
        m_per = a ? ((m_per == PERIOD - 1) ? 0 : m_per + 1) : 0;
        clr = 0; succ = 0; fail = 0;
        if (!m_busy) begin
            if (m_pend && (cyc - m_last_start - 1) >= MIN_GAP) begin
                m_busy = 1; m_start_cyc = cyc + 1; m_seen = 0;
            end
        end else if (cyc == m_start_cyc) begin
            m_last_start = cyc;
        end else if (m_seen) begin
            if (frame_ok(m_frame)) succ = 1; else fail = 1;
            m_busy = 0;
        end else if (d) begin
            m_frame = dt; m_seen = 1;
        end else if (cyc - m_start_cyc == TIMEOUT) begin
            fail = 1; m_busy = 0;
        end
        m_upd = succ;
        m_err = 0;
        if (succ) begin
            m_humi = m_frame[39:32]; m_temp = m_frame[23:16];
            m_valid = 1; m_tries = 0; clr = 1;
        end
        if (fail) begin
            if (m_fails < 255) m_fails++;
            m_tries++;
            if (m_tries == MAXR) begin
                m_err = 1; m_tries = 0; clr = 1;
            end
        end
        if (set) m_pend = 1; else if (clr) m_pend = 0;
        cyc++;
    endtask

    // Reader emulation and DUT event monitors
    int          resp_lat = 0, resp_cnt = 0;
    logic [39:0] resp_frame = '0;
    bit          rnd_mode = 0, req_hold = 0;
    int          n_start = 0, last_start = -1, prev_start = -1;
    int          n_upd = 0, upd_cyc = -1, n_err = 0, done_cyc = -1;

    function automatic logic [39:0] rand_frame();
        logic [7:0] b4, b3, b2, b1, ck;
        b4 = 8'($urandom); b3 = 8'($urandom); b2 = 8'($urandom); b1 = 8'($urandom);
        ck = b4 + b3 + b2 + b1;
        if ($urandom_range(0, 3) == 0) ck = ck ^ 8'h01;
        return {b4, b3, b2, b1, ck};
    endfunction

    task automatic cycle();
        @(negedge clk);
        n_cmp++;
        if (dut_out() !== m_out()) begin
            n_bad++;
            $display("FAIL cycle %0d outputs: got %h expected %h", cyc, dut_out(), m_out());
        end
        if (o_start) begin
            n_start++; prev_start = last_start; last_start = cyc;
            if (rnd_mode) begin
                resp_lat = $urandom_range(0, 55);
                resp_frame = rand_frame();
            end
            resp_cnt = resp_lat;
        end
        if (o_upd) begin n_upd++; upd_cyc = cyc; end
        if (o_err) n_err++;
        if (done) done_cyc = cyc;
        m_step(req, auto_en, done, data);
        @(posedge clk);
        #1;
        req = req_hold;
        done = 1'b0;
        if (resp_cnt == 1) begin
            done = 1'b1; data = resp_frame; resp_cnt = 0;
        end else if (resp_cnt > 1) begin
            resp_cnt--;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_start(input string name, output int sc);
        int n0;
        n0 = n_start;
        for (int k = 0; k < 300 && n_start == n0; k++) cycle();
        chk(name, n_start, n0 + 1);
        sc = last_start;
    endtask

    typedef struct {
        logic [39:0] frame;
        int          starts;
        int          fails;
        int          errs;
        int          upds;
        logic [7:0]  humi;
        logic [7:0]  temp;
    } vec_t;

    vec_t tab[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s1, s2, s0, e0, f0, u0;

        tab[0] = '{40'h2D_00_17_00_44, 1, 0, 0, 1, 8'h2D, 8'h17};
        tab[1] = '{40'h2D_00_17_00_45, 3, 3, 1, 0, 8'h2D, 8'h17};
        tab[2] = '{40'h50_05_1E_03_76, 1, 0, 0, 1, 8'h50, 8'h1E};
        tab[3] = '{40'hFF_FF_FF_FF_FC, 1, 0, 0, 1, 8'hFF, 8'hFF};
        tab[4] = '{40'h10_20_30_40_A1, 3, 3, 1, 0, 8'hFF, 8'hFF};
        tab[5] = '{40'h00_00_00_00_00, 1, 0, 0, 1, 8'h00, 8'h00};
        tab[6] = '{40'h80_01_7F_02_02, 1, 0, 0, 1, 8'h80, 8'h7F};

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", 32'(dut_out()), 0);
        rst_n = 1'b1;
        m_reset();

        // Gap gating after reset, then one good frame 10 cycles after start
        run(2);
        req = 1'b1;
        resp_lat = 10; resp_frame = 40'h2D_00_17_00_44;
        cycle();
        wait_start("first start seen", s1);
        chk("first start cycle", s1, 21);
        chk("state after start", 32'(o_state), 2);
        run(15);
        chk("upd latency", upd_cyc - done_cyc, 2);
        chk("humi first", 32'(o_humi), 45);
        chk("temp first", 32'(o_temp), 23);
        chk("valid first", 32'(o_valid), 1);

        for (int i = 0; i < 7; i++) begin
            s0 = n_start; e0 = n_err; u0 = n_upd; f0 = int'(o_fail_cnt);
            resp_lat = 3; resp_frame = tab[i].frame;
            req = 1'b1;
            run(90);
            chk($sformatf("vec%0d starts", i), n_start - s0, tab[i].starts);
            chk($sformatf("vec%0d fails", i), int'(o_fail_cnt) - f0, tab[i].fails);
            chk($sformatf("vec%0d errs", i), n_err - e0, tab[i].errs);
            chk($sformatf("vec%0d upds", i), n_upd - u0, tab[i].upds);
            chk($sformatf("vec%0d humi", i), 32'(o_humi), 32'(tab[i].humi));
            chk($sformatf("vec%0d temp", i), 32'(o_temp), 32'(tab[i].temp));
            if (tab[i].starts > 1) chk($sformatf("vec%0d spacing", i), last_start - prev_start, 22);
        end

        // Timeout, retry after the gap, then retry count restarts on success
        resp_lat = 0;
        f0 = int'(o_fail_cnt);
        req = 1'b1;
        wait_start("timeout start", s1);
        resp_lat = 5; resp_frame = 40'h2D_00_17_00_44;
        wait_start("retry start", s2);
        chk("retry spacing", s2 - s1, 52);
        chk("timeout fail count", int'(o_fail_cnt), f0 + 1);
        u0 = n_upd;
        run(10);
        chk("retry success upd", n_upd - u0, 1);
        resp_lat = 3; resp_frame = 40'h2D_00_17_00_45;
        s0 = n_start; e0 = n_err;
        req = 1'b1;
        for (int k = 0; k < 200 && n_err == e0; k++) cycle();
        chk("attempts to err", n_start - s0, 3);
        run(30);

        // Periodic triggering
        resp_lat = 1; resp_frame = 40'h50_05_1E_03_76;
        auto_en = 1'b1;
        s0 = n_start;
        run(510);
        chk("auto starts", n_start - s0, 5);
        auto_en = 1'b0;
        s0 = n_start;
        run(300);
        chk("auto off starts", n_start - s0, 0);

        // Request during WAIT and in CHECK; done coincides with timeout
        resp_lat = 50; resp_frame = 40'h00_00_00_00_00;
        f0 = int'(o_fail_cnt); u0 = n_upd;
        req = 1'b1;
        wait_start("coincide start", s1);
        run(4);
        req = 1'b1;
        cycle();
        run(45);
        req = 1'b1;
        cycle();
        wait_start("queued start", s2);
        chk("queued spacing", s2 - s1, 53);
        chk("coincide no fail", int'(o_fail_cnt), f0);
        chk("coincide upd", n_upd - u0, 1);
        run(60);

        // Randomized traffic
        rnd_mode = 1;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) auto_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) req = 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                done = 1'b1; data = rand_frame();
            end
            cycle();
        end
        rnd_mode = 0; auto_en = 1'b0;
        run(120);

        // Fail counter saturation
        resp_lat = 1; resp_frame = 40'h2D_00_17_00_45;
        req_hold = 1; req = 1'b1;
        run(5800);
        req_hold = 0;
        run(80);
        chk("fail saturation", int'(o_fail_cnt), 255);

        // Asynchronous reset in the middle of WAIT
        resp_lat = 0;
        req = 1'b1;
        wait_start("pre-reset start", s1);
        run(5);
        chk("pre-reset state", 32'(o_state), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", 32'(dut_out()), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        resp_cnt = 0; done = 1'b0; req = 1'b0;
        run(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
